// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM states and latency helpers for md_sched
package md_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTLO  = 3'd5;
    localparam md_op_t MD_MTHI  = 3'd6;
    localparam md_op_t MD_ILL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } md_state_e;

    // Busy-cycle count for an op; ops that do not occupy the unit return 0.
    function automatic int unsigned md_lat(input md_op_t op,
                                           input int unsigned mult_lat,
                                           input int unsigned div_lat);
        case (op)
            MD_MULT, MD_MULTU: return mult_lat;
            MD_DIV,  MD_DIVU:  return div_lat;
            default:           return 0;
        endcase
    endfunction

    function automatic logic md_is_long(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// rtl/md_sched_if.sv - pipeline <-> md_sched signal bundle
// master: pipeline side (drives D-stage op/read, stall_other, exc_flush)
// slave : md_sched (drives md_ctr, md_break, stall_md, busy, md_done, md_state)
interface md_sched_if;
    import md_pkg::*;

    md_op_t     d_md_op;
    logic       d_md_read;
    logic       stall_other;
    logic       exc_flush;
    md_op_t     md_ctr;
    logic       md_break;
    logic       stall_md;
    logic       busy;
    logic       md_done;
    logic [1:0] md_state;

    modport master (
        output d_md_op, d_md_read, stall_other, exc_flush,
        input  md_ctr, md_break, stall_md, busy, md_done, md_state
    );

    modport slave (
        input  d_md_op, d_md_read, stall_other, exc_flush,
        output md_ctr, md_break, stall_md, busy, md_done, md_state
    );
endinterface

// File: rtl/md_lat_counter.sv
// rtl/md_lat_counter.sv - latency down-counter for the HI/LO unit model
// clk, reset : clock, synchronous active-high reset
// load_i     : load lat_i - 2 (first RUN cycle already accounts for ISSUE)
// dec_i      : decrement, saturating at zero
// lat_i      : total busy cycles of the op being started
// zero_o     : counter is zero
module md_lat_counter #(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        dec_i,
    input  logic [31:0] lat_i,
    output logic        zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            // ISSUE is busy cycle 1 and the zero cycle is the last, hence -2.
            cnt_d = W'(lat_i - 32'd2);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler: issue, busy tracking, D-stall, cancel
// clk, reset : clock, synchronous active-high reset
// md         : md_sched_if.slave (D-stage op/read, stall_other, exc_flush in;
//              md_ctr, md_break, stall_md, busy, md_done, md_state out)
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_sched_if.slave     md
);
    localparam int CNT_W = $clog2(md_max(MULT_LAT, DIV_LAT));

    md_state_e state_q, state_d;
    md_op_t    md_ctr_q, md_ctr_d;
    md_op_t    op_eff;
    logic      busy, stall_md, advance;
    logic      cnt_load, cnt_dec, cnt_zero;
    logic      md_break, md_done;

    always_comb begin
        // Op 7 is illegal and behaves exactly like "no MD op".
        op_eff   = (md.d_md_op == MD_ILL) ? MD_NONE : md.d_md_op;
        busy     = (state_q != ST_IDLE);
        stall_md = busy & ((op_eff != MD_NONE) | md.d_md_read);
        advance  = (op_eff != MD_NONE) & ~stall_md & ~md.stall_other & ~md.exc_flush;
        md_ctr_d = advance ? op_eff : MD_NONE;
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        md_break = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // mtlo/mthi pulse md_ctr only; they never occupy the unit.
                if (advance && md_is_long(op_eff)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (md.exc_flush) begin
                    md_break = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Committed: exc_flush no longer affects the op.
                if (cnt_zero) begin
                    md_done = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            md_ctr_q <= MD_NONE;
        end else begin
            state_q  <= state_d;
            md_ctr_q <= md_ctr_d;
        end
    end

    // In ISSUE, md_ctr_q still holds the op that was just issued, so it
    // selects the latency to load.
    md_lat_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .lat_i  (32'(md_lat(md_ctr_q, MULT_LAT, DIV_LAT))),
        .zero_o (cnt_zero)
    );

    assign md.md_ctr   = md_ctr_q;
    assign md.md_break = md_break;
    assign md.stall_md = stall_md;
    assign md.busy     = busy;
    assign md.md_done  = md_done;
    assign md.md_state = state_q;
endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - scoreboard bench for md_sched (MULT_LAT=5, DIV_LAT=10)
module tb_md_sched;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_sched_if mif();

    md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    typedef struct {
        string      name;
        logic [8:0] exp;   // {md_ctr, md_break, stall_md, busy, md_done, md_state}
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    exp_t       mon_e;
    logic [8:0] mon_got;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e   = sb.pop_front();
            mon_got = {mif.md_ctr, mif.md_break, mif.stall_md, mif.busy, mif.md_done, mif.md_state};
            tests++;
            if (mon_got !== mon_e.exp) begin
                fails++;
                $display("FAIL %s: got ctr=%0d brk=%0b stall=%0b busy=%0b done=%0b st=%0d, want ctr=%0d brk=%0b stall=%0b busy=%0b done=%0b st=%0d",
                         mon_e.name,
                         mon_got[8:6], mon_got[5], mon_got[4], mon_got[3], mon_got[2], mon_got[1:0],
                         mon_e.exp[8:6], mon_e.exp[5], mon_e.exp[4], mon_e.exp[3], mon_e.exp[2], mon_e.exp[1:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input string name, input logic rst, input logic [2:0] op,
                       input logic rd, input logic so, input logic exc,
                       input logic [2:0] ctr, input logic brk, input logic stl,
                       input logic bsy, input logic done, input logic [1:0] st);
        exp_t e;
        reset           = rst;
        mif.d_md_op     = op;
        mif.d_md_read   = rd;
        mif.stall_other = so;
        mif.exc_flush   = exc;
        e.name = name;
        e.exp  = {ctr, brk, stl, bsy, done, st};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        mif.d_md_op     = 3'd0;
        mif.d_md_read   = 1'b0;
        mif.stall_other = 1'b0;
        mif.exc_flush   = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        cyc("reset", 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("idle",  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // mult then mfhi
        cyc("mul c0", 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("mul c1", 0, 0, 1, 0, 0,  1, 0, 1, 1, 0, 1);
        for (int i = 2; i <= 4; i++)
            cyc($sformatf("mul c%0d", i), 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 2);
        cyc("mul c5", 0, 0, 1, 0, 0,  0, 0, 1, 1, 1, 2);
        cyc("mul c6", 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("mul c7", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // div then back-to-back div held in D
        cyc("div c0", 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("div c1", 0, 3, 0, 0, 0,  3, 0, 1, 1, 0, 1);
        for (int i = 2; i <= 9; i++)
            cyc($sformatf("div c%0d", i), 0, 3, 0, 0, 0,  0, 0, 1, 1, 0, 2);
        cyc("div c10", 0, 3, 0, 0, 0,  0, 0, 1, 1, 1, 2);
        cyc("div c11", 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("div c12", 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 1);
        for (int i = 13; i <= 20; i++)
            cyc($sformatf("div c%0d", i), 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
        cyc("div c21", 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2);
        cyc("div c22", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // exception on issue cycle cancels the op
        cyc("excis c0", 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("excis c1", 0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 1);
        cyc("excis c2", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("excis c3", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // exception during RUN is ignored; stall_other while busy is ignored
        cyc("excrun c0", 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("excrun c1", 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1);
        cyc("excrun c2", 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 2);
        cyc("excrun c3", 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 2);
        cyc("excrun c4", 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 2);
        cyc("excrun c5", 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2);
        cyc("excrun c6", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // mtlo held by stall_other, then issues without occupying the unit
        cyc("mtlo c0", 0, 5, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        cyc("mtlo c1", 0, 5, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        cyc("mtlo c2", 0, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("mtlo c3", 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0);
        cyc("mtlo c4", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // illegal op 7 never issues
        cyc("op7 c0", 0, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("op7 c1", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // exc_flush in IDLE blocks issue without a break pulse
        cyc("excidle c0", 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        cyc("excidle c1", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // mthi issues at the earliest possible edge
        cyc("mthi c0", 0, 6, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("mthi c1", 0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0);

        // reset mid-RUN of a div
        cyc("rst c0", 0, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("rst c1", 0, 0, 0, 0, 0,  4, 0, 0, 1, 0, 1);
        cyc("rst c2", 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
        cyc("rst c3", 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
        cyc("rst c4", 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
        cyc("rst c5", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("rst c6", 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("rst c7", 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1);

        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It sits beside the decode/execute hazard logic and tracks the multi-cycle HI/LO unit. It issues the one-cycle operation code to the unit when a mult/div/mt instruction leaves D, and models the unit's latency with its own counter. It stalls D for any MD instruction or mfhi/mflo while the unit is busy, and cancels a just-issued operation when the issuing instruction is squashed by an exception.

## Interface
Parameters:
- MULT_LAT, default 5: busy cycles for mult/multu; must be ≥ 2.
- DIV_LAT, default 10: busy cycles for div/divu; must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- d_md_op  in  3  MD op of the instruction in D. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi; 7 is illegal and treated as 0.
- d_md_read  in  1  instruction in D is mfhi/mflo.
- stall_other  in  1  D held by another hazard source this cycle.
- exc_flush  in  1  exception taken this cycle; squashes the instructions in D and E.
- md_ctr  out  3  op code to the unit; nonzero for exactly one cycle per issue.
- md_break  out  1  one-cycle cancel pulse to the unit.
- stall_md  out  1  stall request for D.
- busy  out  1  unit occupied.
- md_done  out  1  one-cycle pulse on the last busy cycle.
- md_state  out  2  FSM state, for debug: 0 IDLE, 1 ISSUE, 2 RUN.

## Operation
- Reset: state IDLE, cnt 0. All outputs are 0.
- busy = (state != IDLE).
- stall_md = busy & ((d_md_op != 0) | d_md_read). Combinational.
- Advance = (d_md_op != 0) & ~stall_md & ~stall_other & ~exc_flush.
- On advance, md_ctr is registered to d_md_op for the next cycle; otherwise md_ctr is registered to 0.
- Issue of mult/multu/div/divu: state goes to ISSUE. lat = MULT_LAT for ops 1–2, DIV_LAT for ops 3–4.
- ISSUE with exc_flush: md_break = 1 (combinational) and state goes to IDLE. The op is treated as never started and md_done is not pulsed.
- ISSUE without exc_flush: state goes to RUN with cnt = lat − 2.
- RUN: if cnt == 0, md_done = 1 and state goes to IDLE next edge; otherwise cnt decrements. exc_flush is ignored in RUN because the op is committed.
- mtlo/mthi: md_ctr pulses, state stays IDLE, busy stays 0. These ops are allowed to issue only when IDLE; the stall rule enforces this.
- exc_flush in IDLE: md_break = 0 and no issue occurs.
- reset has priority over everything, including mid-RUN. md_break is not asserted on reset, because the unit resets itself.

## Timing
- Issue edge E0: md_ctr is nonzero during cycle 1.
- busy is high for cycles 1 .. lat, i.e. exactly lat cycles.
- md_done is high in cycle lat.
- A stalled MD instruction or mfhi/mflo in D advances at the end of cycle lat + 1, the first cycle with busy = 0.
- Back-to-back mult: the second mult issues at the end of cycle MULT_LAT + 1.
- md_break is only possible in cycle 1 of an op.
- stall_other during busy has no effect on the counter.

## Structure
- md_pkg holds:
  - the op-code constants (MD_NONE … MD_MTHI);
  - the state enum (ST_IDLE, ST_ISSUE, ST_RUN);
  - a latency function op → lat.
- cnt width is $clog2(max(MULT_LAT, DIV_LAT)).
- One sub-module: md_lat_counter, which handles load/decrement/zero-flag with load value lat − 2. The FSM and stall logic live in md_sched.

## Test plan
- Reset mid-RUN: assert reset during cycle 4 of a div. Next cycle: state 0, busy 0, md_ctr 0, md_break 0.
- Mult then mfhi: d_md_op = 1 at E0, d_md_read = 1 from cycle 1.
  - md_ctr = 1 in cycle 1 only.
  - busy and stall_md are high in cycles 1–5; md_done is high in cycle 5.
  - stall_md = 0 in cycle 6.
- Div then back-to-back div: second d_md_op = 3 is held in D.
  - stall_md is high in cycles 1–10.
  - Second md_ctr = 3 appears in cycle 12; busy stays high through cycle 21.
- Exception on issue: mult issued at E0, exc_flush = 1 in cycle 1.
  - md_break = 1 in cycle 1; state is 0 in cycle 2.
  - md_done is never pulsed.
- Exception in RUN: exc_flush in cycle 3 of a mult.
  - md_break = 0; busy stays high until cycle 5, with md_done in cycle 5.
- mtlo and stall_other:
  - d_md_op = 5 with stall_other = 1 for 2 cycles: md_ctr stays 0. It becomes 5 one cycle after stall_other drops, and busy stays 0.
  - d_md_op = 7: no issue occurs.
